// File: rtl/wb_mtimer.sv
// wb_mtimer -- RISC-V machine timer (mtime / mtimecmp) as a classic
// single-cycle Wishbone slave occupying a 16-byte window.
//
// Register map (wb_adr[3:2], upper address bits ignored):
//   0 : mtime[31:0]      1 : mtime[63:32]
//   2 : mtimecmp[31:0]   3 : mtimecmp[63:32]
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wb_cyc, wb_stb        Wishbone cycle / strobe
//   wb_we                 write enable
//   wb_adr[31:0]          byte address, only [3:2] decoded
//   wb_sel[3:0]           byte lane selects for writes
//   wb_dat_i[31:0]        write data
//   wb_dat_o[31:0]        read data, valid while wb_ack is high
//   wb_ack                one-cycle acknowledge, the cycle after a request
//   wb_err, wb_stall      always 0
//   irq_timer             level interrupt, registered (mtime >= mtimecmp)
module wb_mtimer #(
  parameter int unsigned PRESCALE     = 50,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall,
  output logic        irq_timer
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        irq_q, irq_d;

  logic        req;
  logic        wr;
  logic        tick;
  logic [63:0] mtime_inc;
  logic [31:0] rd_word;
  logic        unused_adr;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
    end
    return r;
  endfunction

  // A request is not accepted while its own ack is still out, which makes
  // back-to-back transfers complete every second cycle.
  assign req  = wb_cyc & wb_stb & ~ack_q;
  assign wr   = req & wb_we;

  assign tick    = (presc_q == PS_LAST);
  assign presc_d = tick ? 16'd0 : presc_q + 16'd1;

  // Unwritten bytes of a colliding write keep the incremented value,
  // so lane merging starts from the post-increment count.
  assign mtime_inc = mtime_q + {63'd0, tick};

  always_comb begin
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    if (wr) begin
      case (wb_adr[3:2])
        2'd0:    mtime_d[31:0]     = merge_lanes(mtime_inc[31:0],   wb_dat_i, wb_sel);
        2'd1:    mtime_d[63:32]    = merge_lanes(mtime_inc[63:32],  wb_dat_i, wb_sel);
        2'd2:    mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0],  wb_dat_i, wb_sel);
        default: mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], wb_dat_i, wb_sel);
      endcase
    end
  end

  // Read data reflects register contents before this cycle's write/increment.
  always_comb begin
    rd_word = 32'd0;
    case (wb_adr[3:2])
      2'd0:    rd_word = mtime_q[31:0];
      2'd1:    rd_word = mtime_q[63:32];
      2'd2:    rd_word = mtimecmp_q[31:0];
      default: rd_word = mtimecmp_q[63:32];
    endcase
  end

  assign ack_d = req;
  assign dat_d = req ? rd_word : dat_q;
  // Compare on the registered values: the irq trails any register change
  // by exactly one cycle.
  assign irq_d = (mtime_q >= mtimecmp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack    = ack_q;
  assign wb_err    = 1'b0;
  assign wb_stall  = 1'b0;
  assign irq_timer = irq_q;

  assign unused_adr = ^{wb_adr[31:4], wb_adr[1:0]};

endmodule

// File: tb/tb_wb_mtimer.sv
// Testbench for wb_mtimer: two instances (PRESCALE=4 and PRESCALE=1) share
// one bus; each is compared every cycle against a 64-bit behavioural model,
// with directed scenarios followed by randomized bus traffic.
module tb_wb_mtimer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic [3:0]  sel = 4'd0;

  logic [31:0] dat4, dat1;
  logic        ack4, ack1, err4, err1, stall4, stall1, irq4, irq1;

  logic [31:0] obs_dat [2];
  logic        obs_ack [2], obs_err [2], obs_stall [2], obs_irq [2];
  assign obs_dat[0] = dat4;   assign obs_dat[1] = dat1;
  assign obs_ack[0] = ack4;   assign obs_ack[1] = ack1;
  assign obs_err[0] = err4;   assign obs_err[1] = err1;
  assign obs_stall[0] = stall4; assign obs_stall[1] = stall1;
  assign obs_irq[0] = irq4;   assign obs_irq[1] = irq1;

  always #5 clk = ~clk;

  wb_mtimer #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_sel(sel), .wb_dat_i(wdat), .wb_dat_o(dat4),
    .wb_ack(ack4), .wb_err(err4), .wb_stall(stall4), .irq_timer(irq4)
  );

  wb_mtimer #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_sel(sel), .wb_dat_i(wdat), .wb_dat_o(dat1),
    .wb_ack(ack1), .wb_err(err1), .wb_stall(stall1), .irq_timer(irq1)
  );

  // Reference model state
  int unsigned P [2] = '{4, 1};
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic [31:0] m_dat  [2];
  logic        m_ack  [2];
  logic        m_irq  [2];
  int unsigned m_k;      // clock edges since reset release

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_time[i] = 64'd0;
      m_cmp[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_dat[i]  = 32'd0;
      m_ack[i]  = 1'b0;
      m_irq[i]  = 1'b0;
    end
    m_k = 0;
  endtask

  // One clock edge of the timer as described by its rules.
  task automatic model_edge();
    bit          rq, tk;
    logic [63:0] ot, oc, nt, nc;
    int          base;
    for (int i = 0; i < 2; i++) begin
      rq = cyc && stb && !m_ack[i];
      tk = ((m_k % P[i]) == P[i] - 1);
      ot = m_time[i];
      oc = m_cmp[i];
      nt = ot + (tk ? 64'd1 : 64'd0);
      nc = oc;
      m_irq[i] = (ot >= oc);
      if (rq) begin
        base = adr[2] ? 32 : 0;
        m_dat[i] = adr[3] ? oc[base +: 32] : ot[base +: 32];
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
              if (adr[3]) nc[base + 8*b +: 8] = wdat[8*b +: 8];
              else        nt[base + 8*b +: 8] = wdat[8*b +: 8];
            end
          end
        end
      end
      m_ack[i]  = rq;
      m_time[i] = nt;
      m_cmp[i]  = nc;
    end
    m_k++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ack[p%0d]", P[i]),   obs_ack[i],   m_ack[i]);
      check($sformatf("irq[p%0d]", P[i]),   obs_irq[i],   m_irq[i]);
      check($sformatf("err[p%0d]", P[i]),   obs_err[i],   1'b0);
      check($sformatf("stall[p%0d]", P[i]), obs_stall[i], 1'b0);
      if (m_ack[i] || !rst_n)
        check($sformatf("dat[p%0d]", P[i]), obs_dat[i], m_dat[i]);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick_clk();
    tick_clk();
    rst_n = 1'b1;
  endtask

  task automatic bus(input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r4, output logic [31:0] r1);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    tick_clk();
    r4 = dat4;
    r1 = dat1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick_clk();
  endtask

  logic [31:0] r4, r1;

  initial begin
    // Reset, then idle: PRESCALE=4 counts 10 in 41 cycles
    do_reset();
    for (int n = 0; n < 41; n++) tick_clk();
    bus(1'b0, 32'h1002_0000, 4'hF, 32'd0, r4, r1);
    check("idle_mtime_p4", r4, 32'd10);
    check("idle_mtime_p1", r1, 32'd41);
    bus(1'b0, 32'h1002_0008, 4'hF, 32'd0, r4, r1);
    check("rst_cmp_lo", r4, 32'hFFFF_FFFF);
    bus(1'b0, 32'h1002_000C, 4'hF, 32'd0, r4, r1);
    check("rst_cmp_hi", r4, 32'hFFFF_FFFF);

    // irq timing with PRESCALE=1
    do_reset();
    bus(1'b1, 32'h1002_0008, 4'hF, 32'd5, r4, r1);
    bus(1'b1, 32'h1002_000C, 4'hF, 32'd0, r4, r1);
    tick_clk();
    check("irq_before", irq1, 1'b0);
    tick_clk();
    check("irq_rise", irq1, 1'b1);
    bus(1'b1, 32'h1002_000C, 4'hF, 32'd1, r4, r1);
    check("irq_drop", irq1, 1'b0);

    // Carry low->high word
    bus(1'b1, 32'h1002_0004, 4'hF, 32'd0, r4, r1);
    bus(1'b1, 32'h1002_0000, 4'hF, 32'hFFFF_FFFE, r4, r1);
    bus(1'b0, 32'h1002_0004, 4'hF, 32'd0, r4, r1);
    check("carry_hi_before", r1, 32'd0);
    bus(1'b0, 32'h1002_0004, 4'hF, 32'd0, r4, r1);
    check("carry_hi_after", r1, 32'd1);

    // 64-bit wrap
    bus(1'b1, 32'h1002_0004, 4'hF, 32'hFFFF_FFFF, r4, r1);
    bus(1'b1, 32'h1002_0000, 4'hF, 32'hFFFF_FFFD, r4, r1);
    bus(1'b0, 32'h1002_0004, 4'hF, 32'd0, r4, r1);
    check("wrap_hi_before", r1, 32'hFFFF_FFFF);
    bus(1'b0, 32'h1002_0004, 4'hF, 32'd0, r4, r1);
    check("wrap_hi_after", r1, 32'd0);

    // Byte lanes, plus a sel=0 write that must change nothing
    bus(1'b1, 32'h1002_0008, 4'hF, 32'h1122_3344, r4, r1);
    bus(1'b1, 32'h1002_0008, 4'b0101, 32'hAABB_CCDD, r4, r1);
    bus(1'b0, 32'h1002_0008, 4'hF, 32'd0, r4, r1);
    check("lanes_p4", r4, 32'h11BB_33DD);
    check("lanes_p1", r1, 32'h11BB_33DD);
    bus(1'b1, 32'hFFFF_FFF8, 4'b0000, 32'h0, r4, r1);
    bus(1'b0, 32'h0000_0008, 4'hF, 32'd0, r4, r1);
    check("sel0_nochange", r1, 32'h11BB_33DD);

    // Write coinciding with a carrying tick
    bus(1'b1, 32'h1002_0004, 4'hF, 32'd0, r4, r1);
    bus(1'b1, 32'h1002_0000, 4'hF, 32'hFFFF_FFFD, r4, r1);
    tick_clk();
    bus(1'b1, 32'h1002_0000, 4'hF, 32'd5, r4, r1);
    bus(1'b0, 32'h1002_0004, 4'hF, 32'd0, r4, r1);
    check("collide_hi", r1, 32'd1);
    bus(1'b0, 32'h1002_0000, 4'hF, 32'd0, r4, r1);
    check("collide_lo", r1, 32'd8);

    // Randomized traffic, including back-to-back requests with cyc held
    for (int n = 0; n < 400; n++) begin
      cyc = ($urandom_range(3) != 0);
      stb = ($urandom_range(3) != 0);
      we  = $urandom_range(1);
      adr = $urandom;
      sel = 4'($urandom);
      case ($urandom_range(3))
        0:       wdat = 32'($urandom_range(63));
        1:       wdat = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        default: wdat = $urandom;
      endcase
      tick_clk();
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick_clk();

    // Reset asserted while a write to mtimecmp is being acked
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1002_000C; sel = 4'hF; wdat = 32'd0;
    tick_clk();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ack_async_p4", ack4, 1'b0);
    check("rst_ack_async_p1", ack1, 1'b0);
    do_reset();
    bus(1'b0, 32'h1002_000C, 4'hF, 32'd0, r4, r1);
    check("rst_cmp_hi_p4", r4, 32'hFFFF_FFFF);
    check("rst_cmp_hi_p1", r1, 32'hFFFF_FFFF);
    bus(1'b0, 32'h1002_0000, 4'hF, 32'd0, r4, r1);
    check("rst_mtime_p4", r4, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
